pixel_stream_source: RTL
========================

// Module: pixel_stream_source
// PURPOSE
//  Camera-side transmitter for the net's pixel-stream input: replays a stored ROWSxCOLS frame as VSYNC/HSYNC/data.
//  Drives the in/HSYNC/VSYNC inputs of the network top on-chip, replacing a physical camera for bring-up and regression.
//  Frame is loaded through a host write port while idle. Frames are emitted once or back-to-back.
// PARAMETERS
//  dataWidth   12    pixel width, matches net dataWidth
//  ROWS        64    active lines per frame
//  COLS        64    active pixels per line (ROWS*COLS = 4096 = net input layer)
//  V_PULSE     4     cycles VSYNC held high at frame start
//  V_BACK      8     idle cycles after VSYNC falls, before first line
//  H_BLANK     16    idle cycles after each line (also after last line)
//  ADDR_W      $clog2(ROWS*COLS)  frame memory address width
// PORTS
//  clk         in   1          single clock, all logic rising-edge
//  reset       in   1          asynchronous, active-high
//  start       in   1          pulse: begin emission (sampled only in IDLE)
//  continuous  in   1          1: restart next frame immediately after last H_BLANK
//  wr_en       in   1          frame memory write strobe
//  wr_addr     in   ADDR_W     pixel address = row*COLS+col
//  wr_data     in   dataWidth  pixel value
//  data_out    out  dataWidth  pixel to net 'in'; 0 when HSYNC low
//  HSYNC       out  1          high exactly during COLS active pixels of a line
//  VSYNC       out  1          high V_PULSE cycles at frame start
//  busy        out  1          high in every state except IDLE
//  frame_done  out  1          1-cycle pulse at end of last H_BLANK of each frame
//  wr_err      out  1          1-cycle pulse: write attempted while busy (dropped)
//  frame_count out  8          frames completed, wraps 255->0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0; memory contents retained (no clear).
//  - FSM: IDLE -> VS (V_PULSE) -> VB (V_BACK) -> ACT (COLS) -> HB (H_BLANK) -> ACT for next row ... -> after HB of row ROWS-1: frame_done, frame_count++, then VS if continuous else IDLE.
//  - start high in IDLE at edge N: VSYNC=1 on cycles N+1..N+V_PULSE; first HSYNC at N+1+V_PULSE+V_BACK.
//  - start while busy ignored. continuous sampled at the last HB cycle only.
//  - Memory: synchronous read, 1-cycle latency. Address pre-issued one cycle before ACT, so data_out and HSYNC register in the same cycle.
//  - ACT cycle k of row r: data_out = mem[r*COLS+k]. HSYNC, VSYNC and data_out all registered, glitch-free.
//  - Column counter wraps COLS-1 -> 0. Row counter wraps ROWS-1 -> 0 at frame end.
//  - VSYNC and HSYNC never high together. HSYNC low for >= H_BLANK cycles between lines.
//  - Writes: accepted in IDLE (visible to the next frame); dropped while busy with wr_err pulse.
//  - Write and start in the same IDLE cycle: write commits; frame uses the new value.
//  - Reset mid-frame: outputs drop to 0 asynchronously. Next frame needs a fresh start.
// CONFIGURATION
//  - PIXEL_SOURCE_TEST_PATTERN_EN defined: memory bypassed.
//    data_out = (r*COLS+k) truncated to dataWidth (ramp); write port still updates memory.
//  - Not defined: pixels come from memory only. Pattern logic absent.
// TESTING  (ROWS=4, COLS=4, V_PULSE=2, V_BACK=3, H_BLANK=2 unless noted)
//  - Load mem[i]=i+100, start at cycle 10 -> VSYNC high 11-12; HSYNC high 16-19 with data 100..103;
//    rows every 6 cycles; frame_done at cycle 39; busy low at 40; frame_count=1.
//  - continuous=1 for 3 frames -> VSYNC re-asserts cycle after each frame_done;
//    frame_count 1,2,3; no extra idle gap.
//  - wr_en at mid-frame, addr 5 data 0xABC -> wr_err 1-cycle pulse; next frame row1 col1 still 105.
//  - reset asserted at row 2 col 1 -> HSYNC/VSYNC/data_out/busy 0 same cycle; start -> full clean frame 100..115.
//  - start pulsed repeatedly while busy -> ignored, exactly one frame_done.
//  - Build with PIXEL_SOURCE_TEST_PATTERN_EN -> data_out 0..15 in raster order regardless of memory contents.

Source files
------------

// File: rtl/pixel_stream_source.sv
// ============================================================================
// Module      : pixel_stream_source
// Description : Camera-side pixel-stream transmitter. Replays a stored
//               ROWS x COLS frame as VSYNC / HSYNC / data_out, once per start
//               or back-to-back when continuous is held high. The frame
//               memory is loaded through a host write port while idle.
// Options     : PIXEL_SOURCE_TEST_PATTERN_EN - when defined, data_out carries
//               a raster-order ramp instead of memory contents (the write
//               port still updates memory).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pixel_stream_source #(
  parameter int dataWidth = 12,
  parameter int ROWS      = 64,
  parameter int COLS      = 64,
  parameter int V_PULSE   = 4,
  parameter int V_BACK    = 8,
  parameter int H_BLANK   = 16,
  parameter int ADDR_W    = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  output logic [dataWidth-1:0] data_out,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 wr_err,
  output logic [7:0]           frame_count
);

  // Shared duration counter covers the longest of the three blanking phases.
  localparam int CNT_MAX = (V_PULSE > V_BACK)
                         ? ((V_PULSE > H_BLANK) ? V_PULSE : H_BLANK)
                         : ((V_BACK  > H_BLANK) ? V_BACK  : H_BLANK);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NPIX    = ROWS * COLS;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_VS   = 3'd1;
  localparam logic [2:0] S_VB   = 3'd2;
  localparam logic [2:0] S_ACT  = 3'd3;
  localparam logic [2:0] S_HB   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic                 frame_end;

  logic                 vsync_q, vsync_d;
  logic                 hsync_q, hsync_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 wr_err_q, wr_err_d;
  logic [7:0]           frame_count_q, frame_count_d;
  logic [dataWidth-1:0] data_q, data_d;
  logic [dataWidth-1:0] pix;

  logic [dataWidth-1:0] mem [NPIX];

  // Frame memory: host writes land only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef PIXEL_SOURCE_TEST_PATTERN_EN
  // Ramp source: the pixel index itself, truncated to the pixel width.
  logic [31:0] ramp;
  assign ramp = 32'(ptr_q);
  assign pix  = ramp[dataWidth-1:0];
`else
  // Memory source: ptr_q is the address of the pixel being fetched this edge.
  assign pix = mem[ptr_q];
`endif

  // State and position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: walk VS -> VB -> (ACT -> HB) x ROWS, then restart or idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_VS;
          cnt_d   = '0;
        end
      end
      S_VS: begin
        if (cnt_q == CNT_W'(V_PULSE - 1)) begin
          state_d = S_VB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VB: begin
        if (cnt_q == CNT_W'(V_BACK - 1)) begin
          state_d = S_ACT;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACT: begin
        if (col_q == COL_W'(COLS - 1)) begin
          state_d = S_HB;
          col_d   = '0;
          cnt_d   = '0;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_HB: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (row_q == ROW_W'(ROWS - 1)) begin
            // continuous is only looked at here, on the final blanking cycle.
            row_d     = '0;
            frame_end = 1'b1;
            state_d   = continuous ? S_VS : S_IDLE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_ACT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The read pointer advances on every edge that enters an active cycle,
    // so the fetch is issued one cycle ahead of the pixel it produces.
    ptr_d = ptr_q;
    if (frame_end) begin
      ptr_d = '0;
    end else if (state_d == S_ACT) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Output decode from the upcoming state, so every output is a flop.
  always_comb begin
    vsync_d       = (state_d == S_VS);
    hsync_d       = (state_d == S_ACT);
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_HB) && (row_d == ROW_W'(ROWS - 1)) &&
                    (cnt_d == CNT_W'(H_BLANK - 1));
    wr_err_d      = wr_en && (state_q != S_IDLE);
    frame_count_d = frame_count_q + {7'd0, frame_end};
    data_d        = (state_d == S_ACT) ? pix : '0;
  end

  // Output registers; reset forces every output low immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_err_q      <= 1'b0;
      frame_count_q <= 8'd0;
      data_q        <= '0;
    end else begin
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      wr_err_q      <= wr_err_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
    end
  end

  assign data_out    = data_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign wr_err      = wr_err_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire
